// File: rtl/fetch_imem_responder.sv
// fetch_imem_responder
//   Instruction-memory model for the responder end of the fetch_out bus.
//   Every read request is captured on the rising clock edge and its word is
//   returned RD_LATENCY cycles later through a fully pipelined shift chain.
//   There is no backpressure, and results come back in request order.
//   The block also counts accepted requests and flags npc/pc sequencing
//   errors.
//
// Optional feature (macro FETCH_IMEM_PARITY_EN):
//   Each word stores an even-parity bit. It is checked when the word is
//   returned. flip_parity(addr) corrupts the stored bit for error injection.
//   Without the macro, no parity is stored and parity_err is tied low.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   instrmem_rd  read request, sampled on the rising edge
//   pc, npc      fetch address and next-pc; valid while instrmem_rd=1
//   load_en      backdoor write strobe for program preload
//   load_addr    backdoor write address
//   load_data    backdoor write data
//   instr_dout   returned word; holds the last delivered word between reads
//   instr_valid  one-cycle pulse per completed read
//   busy         any read in flight
//   rd_count     accepted requests, saturating at 16'hFFFF
//   seq_err      sticky npc != pc+1 error
//   parity_err   sticky parity error (tied to 0 without the macro)
module fetch_imem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instrmem_rd,
  input  logic [15:0]           pc,
  input  logic [15:0]           npc,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic [DATA_W-1:0]     instr_dout,
  output logic                  instr_valid,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic                  seq_err,
  output logic                  parity_err
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("fetch_imem_responder: RD_LATENCY must be in 1..4");
  end

  // Clamped so that an illegal value still elaborates far enough to report.
  localparam int LAT = (RD_LATENCY < 1) ? 1 : (RD_LATENCY > 4) ? 4 : RD_LATENCY;

`ifdef FETCH_IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;
  logic [LAT-1:0]    vld_p;
  logic [WORD_W-1:0] out_in;
  logic              out_in_vld;
  logic [DATA_W-1:0] dout_q;

  assign rd_word = mem[pc[DEPTH_LOG2-1:0]];

`ifdef FETCH_IMEM_PARITY_EN
  assign wr_word = {even_par(load_data), load_data};
`else
  assign wr_word = load_data;
`endif

  // Array write: the read above samples the old word on the same edge,
  // which gives read-before-write for a colliding load and read.
  // The array has no reset, so the program survives reset.
`ifdef FETCH_IMEM_PARITY_EN
  always @(posedge clock) begin
`else
  always_ff @(posedge clock) begin
`endif
    if (load_en) mem[load_addr] <= wr_word;
  end

`ifdef FETCH_IMEM_PARITY_EN
  task automatic flip_parity(input logic [DEPTH_LOG2-1:0] addr);
    mem[addr][DATA_W] = ~mem[addr][DATA_W];
  endtask
`endif

  // Stage boundary: capture -> intermediate data stages (data is not reset)
  if (LAT == 1) begin : g_lat1
    assign out_in     = rd_word;
    assign out_in_vld = instrmem_rd;
  end else begin : g_latn
    logic [WORD_W-1:0] data_p [LAT-1];
    always_ff @(posedge clock) begin
      if (instrmem_rd) data_p[0] <= rd_word;
      for (int i = 1; i < LAT-1; i++) begin
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
    assign out_in     = data_p[LAT-2];
    assign out_in_vld = vld_p[LAT-2];
  end

  // Stage boundary: valid chain, request counter, sequencing check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p    <= '0;
      rd_count <= '0;
      seq_err  <= 1'b0;
    end else begin
      vld_p[0] <= instrmem_rd;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      if (instrmem_rd) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        // The 16-bit add wraps, so pc=FFFF with npc=0000 is legal.
        if (npc != pc + 16'd1) seq_err <= 1'b1;
      end
    end
  end

  // Stage boundary: output register. It loads only on delivery, so it holds
  // the last word while instr_valid is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else if (out_in_vld) begin
      dout_q <= out_in[DATA_W-1:0];
    end
  end

`ifdef FETCH_IMEM_PARITY_EN
  // Checked as the word enters the output register, so the error flag rises
  // in the same cycle as instr_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (out_in_vld && (even_par(out_in[DATA_W-1:0]) != out_in[DATA_W])) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign instr_dout  = dout_q;
  assign instr_valid = vld_p[LAT-1];
  assign busy        = |vld_p;

endmodule

// File: tb/tb_fetch_imem_responder.sv
module tb_fetch_imem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] npc = '0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] instr_dout;
  logic        instr_valid;
  logic        busy;
  logic [15:0] rd_count;
  logic        seq_err;
  logic        parity_err;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_imem_responder #(.DEPTH_LOG2(8), .DATA_W(16), .RD_LATENCY(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .instrmem_rd (instrmem_rd),
    .pc          (pc),
    .npc         (npc),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr_dout  (instr_dout),
    .instr_valid (instr_valid),
    .busy        (busy),
    .rd_count    (rd_count),
    .seq_err     (seq_err),
    .parity_err  (parity_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic [15:0] pc;
    logic [15:0] npc;
    logic        ld;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        e_valid;
    logic [15:0] e_dout;
    logic        e_busy;
    logic [15:0] e_count;
    logic        e_seq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [15:0] p, input logic [15:0] np);
    instrmem_rd = rd;
    pc          = p;
    npc         = np;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  vec_t vt [12];

  initial begin
    // rd  pc       npc      ld  addr   data     valid dout     busy  cnt  seq
    vt[0]  = '{1'b1, 16'h0010, 16'h0011, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'd1, 1'b0};
    vt[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'd1, 1'b0};
    vt[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'd1, 1'b0};
    vt[3]  = '{1'b1, 16'h0010, 16'h0011, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1234, 1'b1, 16'd2, 1'b0};
    vt[4]  = '{1'b1, 16'h0011, 16'h0012, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'd3, 1'b0};
    vt[5]  = '{1'b1, 16'h0012, 16'h0013, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hABCD, 1'b1, 16'd4, 1'b0};
    vt[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0F0F, 1'b1, 16'd4, 1'b0};
    vt[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0F0F, 1'b0, 16'd4, 1'b0};
    vt[8]  = '{1'b1, 16'h0110, 16'h0111, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0F0F, 1'b1, 16'd5, 1'b0};
    vt[9]  = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'd6, 1'b0};
    vt[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h00FF, 1'b1, 16'd6, 1'b0};
    vt[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00FF, 1'b0, 16'd6, 1'b0};

    // Reset state
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_dout",  32'(instr_dout),  32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_count", 32'(rd_count),    32'd0);
    chk("rst_seq",   32'(seq_err),     32'd0);
    chk("rst_par",   32'(parity_err),  32'd0);
    step();
    reset = 1'b1;

    load(8'h10, 16'h1234);
    load(8'h11, 16'hABCD);
    load(8'h12, 16'h0F0F);
    load(8'h20, 16'h2020);
    load(8'hFF, 16'h00FF);

    // Table: single read, back-to-back, address wrap, pc=FFFF wrap
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rd, vt[i].pc, vt[i].npc);
      load_en = vt[i].ld; load_addr = vt[i].ld_addr; load_data = vt[i].ld_data;
      step();
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_dout",  i), 32'(instr_dout),  32'(vt[i].e_dout));
      chk($sformatf("v%0d_busy",  i), 32'(busy),        32'(vt[i].e_busy));
      chk($sformatf("v%0d_count", i), 32'(rd_count),    32'(vt[i].e_count));
      chk($sformatf("v%0d_seq",   i), 32'(seq_err),     32'(vt[i].e_seq));
    end
    load_en = 1'b0;

    // Sequencing error is sticky through later legal reads
    drive(1'b1, 16'h0020, 16'h0025);
    step();
    chk("seq_set",   32'(seq_err),  32'd1);
    chk("seq_count", 32'(rd_count), 32'd7);
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    chk("seq_valid", 32'(instr_valid), 32'd1);
    chk("seq_dout",  32'(instr_dout),  32'h2020);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h0011, 16'h0012);
      step();
      chk($sformatf("seq_hold%0d", i), 32'(seq_err), 32'd1);
    end
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    step();
    chk("seq_cnt17",  32'(rd_count),   32'd17);
    chk("seq_dout2",  32'(instr_dout), 32'hABCD);
    chk("seq_still",  32'(seq_err),    32'd1);

    // Reset with reads in flight
    drive(1'b1, 16'h0010, 16'h0011);
    step();
    drive(1'b1, 16'h0011, 16'h0012);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_dout",  32'(instr_dout),  32'd0);
    chk("mid_rst_busy",  32'(busy),        32'd0);
    chk("mid_rst_count", 32'(rd_count),    32'd0);
    chk("mid_rst_seq",   32'(seq_err),     32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_novalid%0d", i), 32'(instr_valid), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("post_novalid%0d", i), 32'(instr_valid), 32'd0);
      chk($sformatf("post_dout%0d", i),    32'(instr_dout),  32'd0);
    end

    // Memory survives reset
    drive(1'b1, 16'h0010, 16'h0011);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    chk("keep_valid", 32'(instr_valid), 32'd1);
    chk("keep_dout",  32'(instr_dout),  32'h1234);
    chk("keep_count", 32'(rd_count),    32'd1);

    // Same-edge load and read of 0x10: old data first, new data next
    drive(1'b1, 16'h0010, 16'h0011);
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'h5555;
    step();
    load_en = 1'b0;
    drive(1'b1, 16'h0010, 16'h0011);
    step();
    chk("rbw_valid_old", 32'(instr_valid), 32'd1);
    chk("rbw_old",       32'(instr_dout),  32'h1234);
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    chk("rbw_valid_new", 32'(instr_valid), 32'd1);
    chk("rbw_new",       32'(instr_dout),  32'h5555);
    chk("rbw_count",     32'(rd_count),    32'd3);
    chk("rbw_par",       32'(parity_err),  32'd0);
    step();
    chk("rbw_idle",      32'(busy),        32'd0);

`ifdef FETCH_IMEM_PARITY_EN
    dut.flip_parity(8'h11);
    drive(1'b1, 16'h0011, 16'h0012);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    chk("par_valid", 32'(instr_valid), 32'd1);
    chk("par_err",   32'(parity_err),  32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
